// File: rtl/stream_injector.sv
// stream_injector: host-side NoC injection stage.
// A producer writes words on a valid/ready port. Each word is stamped with a
// packet destination and a last flag, then placed in a small fall-through FIFO.
// The FIFO drains as an AXI-Stream master, and every beat carries SRC_ID on TID.
// PKT_CNT_O counts packets whose last beat has been handed downstream.
//
// Optional feature (compile-time macro INJECT_AUTO_LAST_EN):
//   When it is defined, ILAST_I is ignored. An internal beat counter marks
//   every PKT_LEN-th accepted word as last.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising CLK edge where valid && ready. IREADY_O
//   depends only on the registered occupancy and never on AXIS_M_TREADY.
//   Once AXIS_M_TVALID is high, TVALID/TDATA/TLAST/TDEST hold steady until
//   the beat is taken.
module stream_injector #(
  parameter int TDATAW  = 32,
  parameter int TDESTW  = 4,
  parameter int TIDW    = 2,
  parameter int SRC_ID  = 0,
  parameter int DEPTH   = 4,
  parameter int PKT_LEN = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IVALID_I,
  output logic              IREADY_O,
  input  logic [TDATAW-1:0] IDATA_I,
  input  logic [TDESTW-1:0] IDEST_I,
  input  logic              ILAST_I,
  output logic [15:0]       PKT_CNT_O,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TIDW-1:0]   AXIS_M_TID,
  output logic [TDESTW-1:0] AXIS_M_TDEST,
  output logic              dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Reject configurations the pointer arithmetic cannot support.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PKT_LEN < 1) begin : g_bad_param
    $error("stream_injector: DEPTH must be a power of two >= 2 and PKT_LEN >= 1");
  end

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } wr_state_t;

  wr_state_t         state;
  logic [TDESTW-1:0] dest_reg;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [15:0]       pkt_cnt;

  logic [TDATAW-1:0] mem_data [DEPTH];
  logic [TDESTW-1:0] mem_dest [DEPTH];
  logic              mem_last [DEPTH];

  logic              push;
  logic              pop;
  logic              in_last;
  logic [TDESTW-1:0] in_dest;

  assign IREADY_O      = (count != FULL_CNT);
  assign AXIS_M_TVALID = (count != '0);
  assign push          = IVALID_I && IREADY_O;
  assign pop           = AXIS_M_TVALID && AXIS_M_TREADY;

  // The head word of a packet supplies the destination, and later words reuse it.
  assign in_dest = (state == HEAD) ? IDEST_I : dest_reg;

`ifdef INJECT_AUTO_LAST_EN
  localparam int BCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(PKT_LEN - 1);

  logic [BCW-1:0] beat_cnt;
  logic           unused_ilast;

  assign unused_ilast = ILAST_I;
  assign in_last      = (beat_cnt == LAST_BEAT);

  // Count accepted words within the current packet. The counter wraps after the generated last word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      beat_cnt <= '0;
    end else if (push) begin
      beat_cnt <= in_last ? '0 : beat_cnt + BCW'(1);
    end
  end
`else
  assign in_last = ILAST_I;
`endif

  // Write-side packet FSM: latch the head destination and track packet boundaries.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= HEAD;
      dest_reg <= '0;
    end else if (push) begin
      case (state)
        HEAD: begin
          dest_reg <= IDEST_I;
          state    <= in_last ? HEAD : BODY;
        end
        BODY: begin
          if (in_last) state <= HEAD;
        end
        default: state <= HEAD;
      endcase
    end
  end

  assign dbg_state = state;

  // FIFO storage. It is cleared on reset so that a flushed packet leaves no stale contents.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_dest[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else if (push) begin
      mem_data[wr_ptr] <= IDATA_I;
      mem_dest[wr_ptr] <= in_dest;
      mem_last[wr_ptr] <= in_last;
    end
  end

  // FIFO pointers and occupancy. Push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Count packets whose last beat has been accepted downstream. The counter wraps at 16 bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pkt_cnt <= '0;
    end else if (pop && mem_last[rd_ptr]) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  assign PKT_CNT_O = pkt_cnt;

  // The stream outputs show the FIFO head and read as zero when the FIFO is empty.
  assign AXIS_M_TDATA = AXIS_M_TVALID ? mem_data[rd_ptr] : '0;
  assign AXIS_M_TDEST = AXIS_M_TVALID ? mem_dest[rd_ptr] : '0;
  assign AXIS_M_TLAST = AXIS_M_TVALID ? mem_last[rd_ptr] : 1'b0;
  assign AXIS_M_TID   = TIDW'(SRC_ID);

endmodule

// File: tb/tb_stream_injector.sv
// Bench for stream_injector: directed vector table, multi-cycle corner sequences
// and randomized traffic, checked against a queue-based reference model.
// The bench follows INJECT_AUTO_LAST_EN when that macro is defined.
module tb_stream_injector;

  localparam int TDATAW  = 32;
  localparam int TDESTW  = 4;
  localparam int TIDW    = 2;
  localparam int SRC_ID  = 0;
  localparam int DEPTH   = 4;
  localparam int PKT_LEN = 4;
  localparam int BW      = TDATAW + TDESTW + 1;

  logic              clk;
  logic              rst_n;
  logic              ivalid;
  logic              iready;
  logic [TDATAW-1:0] idata;
  logic [TDESTW-1:0] idest;
  logic              ilast;
  logic [15:0]       pkt_cnt;
  logic              tvalid;
  logic              tready;
  logic [TDATAW-1:0] tdata;
  logic              tlast;
  logic [TIDW-1:0]   tid;
  logic [TDESTW-1:0] tdest;
  logic              dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  stream_injector #(
    .TDATAW(TDATAW), .TDESTW(TDESTW), .TIDW(TIDW),
    .SRC_ID(SRC_ID), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .IVALID_I(ivalid), .IREADY_O(iready), .IDATA_I(idata),
    .IDEST_I(idest), .ILAST_I(ilast), .PKT_CNT_O(pkt_cnt),
    .AXIS_M_TVALID(tvalid), .AXIS_M_TREADY(tready), .AXIS_M_TDATA(tdata),
    .AXIS_M_TLAST(tlast), .AXIS_M_TID(tid), .AXIS_M_TDEST(tdest),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n  = 1'b0;
    ivalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [TDATAW-1:0] d,
                       input logic [TDESTW-1:0] t, input logic l);
    ivalid = v;
    idata  = d;
    idest  = t;
    ilast  = l;
  endtask

  // ---------------- reference model / scoreboard ----------------
  // The expected FIFO contents are packed {data, dest, last}. The model
  // predicts each edge from the input rules: accept when fewer than DEPTH
  // words are held, drain when the queue is non-empty and TREADY is high.
  logic [BW-1:0] exp_q[$];
  bit            m_in_pkt;
  logic [TDESTW-1:0] m_dest;
  int            m_beat;
  logic [15:0]   m_pkt;
  bit            prev_stall;
  logic [BW-1:0] prev_out;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_in_pkt   = 0;
      m_dest     = '0;
      m_beat     = 0;
      m_pkt      = '0;
      prev_stall = 0;
      check("mon_rst_tvalid", 64'(tvalid), 64'(0));
      check("mon_rst_iready", 64'(iready), 64'(1));
      check("mon_rst_pkt", 64'(pkt_cnt), 64'(0));
    end else begin
      bit push_ok;
      bit pop_ok;
      bit w_last;
      logic [TDESTW-1:0] w_dest;
      check("mon_tvalid", 64'(tvalid), 64'(exp_q.size() != 0));
      check("mon_iready", 64'(iready), 64'(exp_q.size() != DEPTH));
      check("mon_pkt", 64'(pkt_cnt), 64'(m_pkt));
      check("mon_tid", 64'(tid), 64'(SRC_ID));
      if (exp_q.size() != 0) check("mon_head", 64'({tdata, tdest, tlast}), 64'(exp_q[0]));
      if (prev_stall) check("mon_stable", 64'({tvalid, tdata, tdest, tlast}), 64'({1'b1, prev_out}));
      prev_stall = (exp_q.size() != 0) && !tready;
      prev_out   = {tdata, tdest, tlast};
      push_ok = ivalid && (exp_q.size() != DEPTH);
      pop_ok  = (exp_q.size() != 0) && tready;
      if (pop_ok) begin
        if (exp_q[0][0]) m_pkt = m_pkt + 16'd1;
        void'(exp_q.pop_front());
      end
      if (push_ok) begin
`ifdef INJECT_AUTO_LAST_EN
        w_last = (m_beat == PKT_LEN - 1);
        m_beat = w_last ? 0 : m_beat + 1;
`else
        w_last = ilast;
`endif
        w_dest   = m_in_pkt ? m_dest : idest;
        m_dest   = w_dest;
        m_in_pkt = !w_last;
        exp_q.push_back({idata, w_dest, w_last});
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [TDATAW-1:0] d;
    logic [TDESTW-1:0] t;
    logic              l;
    logic [TDESTW-1:0] exp_t;
    logic              exp_l;
    logic [15:0]       exp_pkt;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin
    rst_n  = 1'b0;
    tready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);

    vecs[0] = '{32'hA5A5_0001, 4'd3, 1'b1, 4'd3, 1'b1, 16'd0};
    vecs[1] = '{32'h0000_1111, 4'd5, 1'b0, 4'd5, 1'b0, 16'd1};
    vecs[2] = '{32'h0000_2222, 4'd9, 1'b0, 4'd5, 1'b0, 16'd1};
    vecs[3] = '{32'h0000_3333, 4'd9, 1'b1, 4'd5, 1'b1, 16'd1};
    vecs[4] = '{32'hDEAD_0004, 4'd7, 1'b0, 4'd7, 1'b0, 16'd2};
    vecs[5] = '{32'hBEEF_0005, 4'd2, 1'b1, 4'd7, 1'b1, 16'd2};

    reset_dut();

    // Reset state
    check("rst_iready", 64'(iready), 64'(1));
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tdata", 64'(tdata), 64'(0));
    check("rst_tlast", 64'(tlast), 64'(0));
    check("rst_tdest", 64'(tdest), 64'(0));
    check("rst_tid", 64'(tid), 64'(SRC_ID));
    check("rst_pkt", 64'(pkt_cnt), 64'(0));

`ifndef INJECT_AUTO_LAST_EN
    // Table: one word per cycle with TREADY high. Each word appears in the cycle after its accept.
    tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].d, vecs[i].t, vecs[i].l);
      step();
      check($sformatf("vec%0d_tvalid", i), 64'(tvalid), 64'(1));
      check($sformatf("vec%0d_tdata", i), 64'(tdata), 64'(vecs[i].d));
      check($sformatf("vec%0d_tdest", i), 64'(tdest), 64'(vecs[i].exp_t));
      check($sformatf("vec%0d_tlast", i), 64'(tlast), 64'(vecs[i].exp_l));
      check($sformatf("vec%0d_pkt", i), 64'(pkt_cnt), 64'(vecs[i].exp_pkt));
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("vec_end_pkt", 64'(pkt_cnt), 64'(3));
    check("vec_end_tvalid", 64'(tvalid), 64'(0));
`endif

    // Full FIFO: present 5 words while TREADY is low. The fifth word must be refused.
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hF000_0000 + 32'(i), 4'hA, 1'(i % 2));
      step();
      if (i == 3) check("full_iready_low", 64'(iready), 64'(0));
    end
    check("full_still_low", 64'(iready), 64'(0));
    check("full_head", 64'(tdata), 64'(32'hF000_0000));
    drive(1'b0, '0, '0, 1'b0);
    tready = 1'b1;
    step();
    check("full_release_iready", 64'(iready), 64'(1));
    check("full_second_word", 64'(tdata), 64'(32'hF000_0001));
    repeat (DEPTH) step();
    check("full_drained", 64'(tvalid), 64'(0));

    // TREADY toggles every cycle while the producer streams continuously.
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, $urandom, 4'($urandom_range(0, 15)), 1'(i % 3 == 2));
      tready = 1'(i % 2);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    tready = 1'b1;
    repeat (DEPTH + 2) step();

    // Randomized traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) == 0));
      tready = 1'($urandom_range(0, 2) != 0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    tready = 1'b1;
    repeat (DEPTH + 2) step();

    // Reset arrives mid-packet: two beats of a four-beat packet are buffered.
    tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h6000_0000 + 32'(i), 4'd6, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid", 64'(tvalid), 64'(0));
    check("rst_mid_iready", 64'(iready), 64'(1));
    check("rst_mid_tdata", 64'(tdata), 64'(0));
    check("rst_mid_tdest", 64'(tdest), 64'(0));
    check("rst_mid_tlast", 64'(tlast), 64'(0));
    check("rst_mid_pkt", 64'(pkt_cnt), 64'(0));
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    tready = 1'b1;
    drive(1'b1, 32'h0000_1234, 4'hB, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    check("post_rst_tvalid", 64'(tvalid), 64'(1));
    check("post_rst_tdest", 64'(tdest), 64'(4'hB));
`ifdef INJECT_AUTO_LAST_EN
    check("post_rst_tlast", 64'(tlast), 64'(0));
`else
    check("post_rst_tlast", 64'(tlast), 64'(1));
`endif
    step();

`ifdef INJECT_AUTO_LAST_EN
    // Auto-last: eight words with ILAST_I low form two packets of PKT_LEN beats.
    reset_dut();
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hA000_0000 + 32'(i), 4'(i), 1'b0);
      step();
      check($sformatf("auto%0d_tlast", i), 64'(tlast), 64'(i % PKT_LEN == PKT_LEN - 1));
      check($sformatf("auto%0d_tdest", i), 64'(tdest), 64'((i / PKT_LEN) * PKT_LEN));
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("auto_pkt", 64'(pkt_cnt), 64'(2));
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_injector.md
# stream_injector

Host-side injection stage that feeds the NoC: accepts words from a local producer on a simple valid/ready write port, groups them into packets, buffers them in a small FIFO and presents them as an AXI-Stream master toward the router and, ultimately, the destination sink. It stamps every beat with this node's source ID and a per-packet destination. It also keeps a count of packets fully handed to the network.

## Interface
- TDATAW, 32, data width
- TDESTW, 4, destination field width
- TIDW, 2, source ID width
- SRC_ID, 0, constant driven on AXIS_M_TID
- DEPTH, 4, FIFO entries; power of two, ≥2
- PKT_LEN, 4, beats per packet in auto-last mode; ≥1

- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- IVALID_I  in  1  producer word valid
- IREADY_O  out  1  injector can accept a word
- IDATA_I  in  TDATAW  producer word
- IDEST_I  in  TDESTW  destination; sampled on a packet's first beat only
- ILAST_I  in  1  producer marks last word of packet
- PKT_CNT_O  out  16  packets whose last beat completed on AXIS_M
- AXIS_M_TVALID  out  1  master valid
- AXIS_M_TREADY  in  1  downstream ready
- AXIS_M_TDATA  out  TDATAW  beat data
- AXIS_M_TLAST  out  1  last beat of packet
- AXIS_M_TID  out  TIDW  always SRC_ID
- AXIS_M_TDEST  out  TDESTW  packet destination

## Operation
- Write accept: IVALID_I && IREADY_O at a rising edge pushes {IDATA_I, dest, last} into FIFO.
- IREADY_O = (count != DEPTH); depends only on registered count, never on AXIS_M_TREADY. A full FIFO refuses a push even if a pop happens the same cycle.
- Write-side FSM, states HEAD/BODY; reset state HEAD.
  - HEAD: on an accepted word, the destination is IDEST_I; it is latched into dest_reg. If the word is not last, go to BODY.
  - BODY: on an accepted word, the destination is dest_reg (IDEST_I ignored). On the last word, return to HEAD.
  - No acceptance: hold state.
- Read side: AXIS_M_TVALID = (count != 0). TDATA/TLAST/TDEST come from the FIFO head. AXIS_M_TID = SRC_ID constant.
- Pop on AXIS_M_TVALID && AXIS_M_TREADY; rd_ptr advances and wraps modulo DEPTH.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- PKT_CNT_O increments by 1 on every pop whose TLAST=1. It is 16-bit and wraps 0xFFFF→0x0000.
- Pointers are log2(DEPTH) bits. count is log2(DEPTH)+1 bits.

## Timing
- Reset values: IREADY_O=1, AXIS_M_TVALID=0, AXIS_M_TDATA=0, AXIS_M_TLAST=0, AXIS_M_TDEST=0, AXIS_M_TID=SRC_ID, PKT_CNT_O=0. FSM=HEAD; pointers, count and dest_reg cleared.
- Latency: a word accepted at edge N is visible with AXIS_M_TVALID=1 in the cycle after edge N (1-cycle fall-through minimum).
- AXI-Stream rule: once TVALID=1, TVALID/TDATA/TLAST/TDEST stay stable until the handshake completes.
- Throughput: 1 beat/cycle sustained when TREADY is held high and the producer is continuous.
- Full: after DEPTH accepts with no pop, IREADY_O=0 from the next cycle. It returns to 1 the cycle after the first pop.
- Reset asserted mid-packet: the FIFO is flushed and the FSM is forced to HEAD asynchronously. The partial packet is discarded, and the next accepted word is treated as a head.

## Configuration
- INJECT_AUTO_LAST_EN defined:
  - ILAST_I is ignored.
  - A beat counter (0..PKT_LEN-1, reset 0) counts accepted words. The word at count PKT_LEN-1 is marked last, and the counter wraps to 0.
  - The FSM uses this generated last. With PKT_LEN=1, every word is HEAD and last.
- Undefined: the last flag is ILAST_I, there is no beat counter, and PKT_LEN is unused.

## Test plan
- Reset, then push one word with IDATA_I=0xA5A5_0001, IDEST_I=3, ILAST_I=1, TREADY=1.
  - Expect: TVALID one cycle later, TDATA=0xA5A5_0001, TDEST=3, TLAST=1, TID=SRC_ID; PKT_CNT_O=1 after the handshake.
- 3-beat packet with IDEST_I=5,9,9 on the beats.
  - Expect: all three beats carry TDEST=5 (head latched) and only beat 3 has TLAST=1.
- Hold TREADY=0 and push 5 words with DEPTH=4.
  - Expect: IREADY_O=0 after the 4th accept and the 5th word is not taken.
  - Expect: releasing TREADY drains the words in order, and IREADY_O rises the cycle after the first pop.
- Toggle TREADY every cycle mid-packet.
  - Expect: TDATA/TLAST/TDEST stable while stalled, no beat lost or duplicated.
- Deassert RST_N after 2 beats of a 4-beat packet.
  - Expect: all outputs return to reset values, and the next word takes the new IDEST_I.
- With INJECT_AUTO_LAST_EN and PKT_LEN=4, push 8 words with ILAST_I=0.
  - Expect: TLAST on beats 4 and 8, and PKT_CNT_O=2.
